// File: rtl/pc_ctrl_unit.sv
// Program-counter controller: holds the PC, picks the next PC from
// jump / branch / sequential increment, and gates updates through a
// RUN / HALT / STEP debug FSM. Retired updates are counted (saturating).
module pc_ctrl_unit #(
   parameter int unsigned        WIDTH      = 32,
   parameter logic [WIDTH-1:0]   RESET_VEC  = '0,
   parameter int unsigned        INC        = 4,
   parameter int unsigned        ALIGN_BITS = 2,
   parameter int unsigned        CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 halt,
   input  logic                 cont,
   input  logic                 step,
   input  logic                 br_taken,
   input  logic [WIDTH-1:0]     br_target,
   input  logic                 jmp_en,
   input  logic [WIDTH-1:0]     jmp_target,
   output logic [WIDTH-1:0]     pc,
   output logic [WIDTH-1:0]     pc_next,
   output logic                 halted,
   output logic                 misalign_err,
   output logic [CNT_WIDTH-1:0] retire_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } state_t;

   // Low bits a taken target must have clear; zero-width alignment gives an empty mask.
   localparam logic [WIDTH-1:0] AMASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] tgt;
   logic             tgt_sel;
   logic             tgt_mis;
   logic             upd_en;

   // Next-PC select: jump beats branch beats sequential; targets are forced aligned.
   always_comb begin
      tgt     = '0;
      tgt_sel = 1'b0;
      pc_next = pc + WIDTH'(INC);
      if (jmp_en) begin
         tgt     = jmp_target;
         tgt_sel = 1'b1;
      end else if (br_taken) begin
         tgt     = br_target;
         tgt_sel = 1'b1;
      end
      tgt_mis = tgt_sel && ((tgt & AMASK) != '0);
      if (tgt_sel)
         pc_next = tgt & ~AMASK;
   end

   // Commit enable: free-running in RUN unless halting, one shot in STEP.
   always_comb begin
      upd_en = ((state == RUN) && !halt && !stall) ||
               ((state == STEP) && !stall);
   end

   // FSM next state; in HALT a simultaneous cont and step resolves to cont.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (halt)       state_nxt = HALT;
         HALT:    if (cont)       state_nxt = RUN;
                  else if (step)  state_nxt = STEP;
         STEP:    if (!stall)     state_nxt = HALT;
         default:                 state_nxt = RUN;
      endcase
   end

   // State register and the registered halted flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= (state_nxt != RUN);
      end
   end

   // PC register and misalignment pulse, both gated by the commit enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= RESET_VEC;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= upd_en && tgt_mis;
         if (upd_en)
            pc <= pc_next;
      end
   end

   // Retire counter: one per committed update, sticks at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         retire_cnt <= '0;
      else if (upd_en && (retire_cnt != '1))
         retire_cnt <= retire_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Directed bench for pc_ctrl_unit: a default instance plus a 2-bit
// retire-counter instance sharing the same stimulus.
module tb_pc_ctrl_unit;

   logic        clk, rst;
   logic        stall, halt, cont, step, br_taken, jmp_en;
   logic [31:0] br_target, jmp_target;
   logic [31:0] pc, pc_next, pc2, pc_next2;
   logic        halted, misalign_err, halted2, misalign_err2;
   logic [31:0] retire_cnt;
   logic [1:0]  retire_cnt2;

   int checks = 0;
   int errors = 0;

   pc_ctrl_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .cont(cont), .step(step),
      .br_taken(br_taken), .br_target(br_target), .jmp_en(jmp_en), .jmp_target(jmp_target),
      .pc(pc), .pc_next(pc_next), .halted(halted), .misalign_err(misalign_err),
      .retire_cnt(retire_cnt)
   );

   pc_ctrl_unit #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .cont(cont), .step(step),
      .br_taken(br_taken), .br_target(br_target), .jmp_en(jmp_en), .jmp_target(jmp_target),
      .pc(pc2), .pc_next(pc_next2), .halted(halted2), .misalign_err(misalign_err2),
      .retire_cnt(retire_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 0; halt = 0; cont = 0; step = 0;
      br_taken = 0; br_target = '0; jmp_en = 0; jmp_target = '0;
      #2 rst = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_mis", {31'b0, misalign_err}, 32'h0);
      check("rst_cnt", retire_cnt, 32'h0);
      #9 rst = 1'b1;

      // free run
      tick(); check("run1", pc, 32'h4);
      tick(); check("run2", pc, 32'h8);
      tick(); check("run3", pc, 32'hC);
      check("cnt3", retire_cnt, 32'd3);
      check("cnt3_w2", {30'b0, retire_cnt2}, 32'd3);

      // jump beats branch
      jmp_en = 1; jmp_target = 32'h100; br_taken = 1; br_target = 32'h200;
      #1 check("pcn_jmp", pc_next, 32'h100);
      tick(); check("jmp_win", pc, 32'h100);
      check("jmp_mis", {31'b0, misalign_err}, 32'h0);
      check("sat_w2", {30'b0, retire_cnt2}, 32'd3);

      // misaligned branch target
      jmp_en = 0; br_target = 32'h103;
      #1 check("pcn_mis", pc_next, 32'h100);
      tick(); check("br_mis_pc", pc, 32'h100);
      check("br_mis_pulse", {31'b0, misalign_err}, 32'h1);
      br_taken = 0;
      tick(); check("seq_after_br", pc, 32'h104);
      check("mis_one_cycle", {31'b0, misalign_err}, 32'h0);

      // go to 0x20, then halt
      jmp_en = 1; jmp_target = 32'h20;
      tick(); check("jmp20", pc, 32'h20);
      jmp_en = 0; halt = 1;
      tick(); check("halt_pc", pc, 32'h20);
      check("halt_flag", {31'b0, halted}, 32'h1);
      halt = 0;
      tick(); check("halt_hold", pc, 32'h20);

      // two single steps
      step = 1; tick(); step = 0;
      check("step_enter", pc, 32'h20);
      check("step_halted", {31'b0, halted}, 32'h1);
      tick(); check("step1", pc, 32'h24);
      step = 1; tick(); step = 0;
      tick(); check("step2", pc, 32'h28);
      check("step2_halted", {31'b0, halted}, 32'h1);

      // stalled step
      step = 1; tick(); step = 0; stall = 1;
      tick(); check("sstall1", pc, 32'h28);
      tick(); check("sstall2", pc, 32'h28);
      tick(); check("sstall3", pc, 32'h28);
      check("sstall_halted", {31'b0, halted}, 32'h1);
      stall = 0;
      tick(); check("sstall_commit", pc, 32'h2C);
      tick(); check("back_halt", pc, 32'h2C);
      check("back_halt_flag", {31'b0, halted}, 32'h1);

      // continue
      cont = 1; tick(); cont = 0;
      check("cont_nupd", pc, 32'h2C);
      check("cont_run", {31'b0, halted}, 32'h0);
      tick(); check("resume", pc, 32'h30);

      // cont and step together: cont wins
      halt = 1; tick(); halt = 0;
      check("halt2", pc, 32'h30);
      cont = 1; step = 1; tick(); cont = 0; step = 0;
      check("cont_wins", {31'b0, halted}, 32'h0);
      check("cont_wins_pc", pc, 32'h30);
      tick(); check("run_again", pc, 32'h34);

      // stall in RUN, and no misalign pulse on an uncommitted branch
      stall = 1; br_taken = 1; br_target = 32'h103;
      tick(); check("run_stall", pc, 32'h34);
      check("mis_nocommit", {31'b0, misalign_err}, 32'h0);
      stall = 0; br_taken = 0;
      check("cnt12", retire_cnt, 32'd12);
      check("cnt_sat_w2", {30'b0, retire_cnt2}, 32'd3);

      // wrap
      jmp_en = 1; jmp_target = 32'hFFFF_FFFC;
      tick(); check("top", pc, 32'hFFFF_FFFC);
      jmp_en = 0;
      tick(); check("wrap", pc, 32'h0);
      check("cnt14", retire_cnt, 32'd14);

      // async reset while halted
      halt = 1; tick(); halt = 0;
      check("pre_rst_halted", {31'b0, halted}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_halted", {31'b0, halted}, 32'h0);
      check("mid_rst_cnt", retire_cnt, 32'h0);
      #2 rst = 1'b1;
      tick(); check("post_rst", pc, 32'h4);
      check("post_rst_cnt", retire_cnt, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
